// File: rtl/q_policy_reader_pkg.sv
// Shared definitions for the Q-table read-side agent: default widths,
// FSM encoding and the LFSR constants used by the exploration logic.
package q_policy_reader_pkg;

    localparam int QP_DATA_WIDTH    = 16;
    localparam int QP_STATES_WIDTH  = 4;
    localparam int QP_ACTIONS_WIDTH = 2;
    localparam int QP_ACTIONS       = 4;

    // Fibonacci LFSR x^16+x^14+x^13+x^11 in right-shift form: the feedback
    // is the XOR of bits 0, 2, 3 and 5 and enters at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/q_policy_reader_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances on every clock, seeded on reset.
module lfsr16
    import q_policy_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    // NOTE: async reset belongs in the sensitivity list, and state uses <= so
    // every register samples its inputs from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/q_policy_reader.sv
// Scans Q(s,*) over one synchronous read port and returns the argmax action
// and its value, optionally replacing the action with an epsilon-greedy pick.
module q_policy_reader
    import q_policy_reader_pkg::*;
#(
    parameter int          DATA_WIDTH    = QP_DATA_WIDTH,
    parameter int          STATES_WIDTH  = QP_STATES_WIDTH,
    parameter int          ACTIONS_WIDTH = QP_ACTIONS_WIDTH,
    parameter int          ACTIONS       = QP_ACTIONS,
    parameter logic [15:0] EPSILON       = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [STATES_WIDTH-1:0]  req_state,
    input  logic                     explore_en,
    output logic                     rd_en,
    output logic [STATES_WIDTH-1:0]  rd_state,
    output logic [ACTIONS_WIDTH-1:0] rd_action,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ACTIONS_WIDTH-1:0] rsp_action,
    output logic [DATA_WIDTH-1:0]    rsp_max_q,
    output logic                     rsp_explored
);

    localparam logic [ACTIONS_WIDTH-1:0] LAST_ACTION = ACTIONS_WIDTH'(ACTIONS - 1);
    localparam logic [ACTIONS_WIDTH:0]   ACTIONS_EXT = (ACTIONS_WIDTH + 1)'(ACTIONS);

    state_t state;
    state_t state_next;

    logic [15:0]                    lfsr_q;
    logic [STATES_WIDTH-1:0]        cap_state;
    logic                           explore_flag;
    logic [ACTIONS_WIDTH-1:0]       explore_cand;
    logic [ACTIONS_WIDTH-1:0]       addr_cnt;
    logic                           data_valid;
    logic [ACTIONS_WIDTH-1:0]       data_action;
    logic signed [DATA_WIDTH-1:0]   best_q;
    logic [ACTIONS_WIDTH-1:0]       best_a;
    logic                           accept;
    logic [ACTIONS_WIDTH:0]         cand_raw;
    logic [ACTIONS_WIDTH:0]         cand_wrap;
    logic [ACTIONS_WIDTH-1:0]       cand_next;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign accept = (state == IDLE) && req_valid;

    // Non-power-of-two action counts fold the out-of-range candidates back.
    assign cand_raw  = {1'b0, lfsr_q[ACTIONS_WIDTH-1:0]};
    assign cand_wrap = cand_raw - ACTIONS_EXT;
    assign cand_next = (cand_raw >= ACTIONS_EXT) ? cand_wrap[ACTIONS_WIDTH-1:0]
                                                 : cand_raw[ACTIONS_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rd_en      = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = SCAN;
            end
            SCAN: begin
                rd_en = 1'b1;
                if (addr_cnt == LAST_ACTION) state_next = DRAIN;
            end
            DRAIN: state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_state    <= '0;
            explore_flag <= 1'b0;
            explore_cand <= '0;
            addr_cnt     <= '0;
        end else if (accept) begin
            cap_state    <= req_state;
            explore_flag <= explore_en && (lfsr_q < EPSILON);
            explore_cand <= cand_next;
            addr_cnt     <= '0;
        end else if (state == SCAN && addr_cnt != LAST_ACTION) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // rd_data lags rd_en by one cycle, so the compare runs one step behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid  <= 1'b0;
            data_action <= '0;
            best_q      <= '0;
            best_a      <= '0;
        end else begin
            data_valid  <= rd_en;
            data_action <= rd_action;
            if (data_valid) begin
                if (data_action == '0 || $signed(rd_data) > best_q) begin
                    best_q <= $signed(rd_data);
                    best_a <= data_action;
                end
            end
        end
    end

    assign rd_state     = rd_en ? cap_state : '0;
    assign rd_action    = rd_en ? addr_cnt  : '0;
    assign rsp_action   = rsp_valid ? (explore_flag ? explore_cand : best_a) : '0;
    assign rsp_max_q    = rsp_valid ? best_q : '0;
    assign rsp_explored = rsp_valid & explore_flag;

endmodule

// File: tb/tb_q_policy_reader.sv
// Self-checking bench for q_policy_reader: Q-RAM model, reference LFSR and a
// scoreboard of expected responses compared at each response handshake.
module tb_q_policy_reader;

    localparam logic [15:0] EPS = 16'hFFFF;

    typedef struct {
        logic [1:0]  action;
        logic [15:0] max_q;
        logic        explored;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_state;
    logic        explore_en;
    logic        rd_en;
    logic [3:0]  rd_state;
    logic [1:0]  rd_action;
    logic [15:0] rd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_action;
    logic [15:0] rsp_max_q;
    logic        rsp_explored;

    logic [15:0] mem [16][4];
    logic [15:0] tb_lfsr;
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    q_policy_reader #(
        .DATA_WIDTH    (16),
        .STATES_WIDTH  (4),
        .ACTIONS_WIDTH (2),
        .ACTIONS       (4),
        .EPSILON       (EPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_state    (req_state),
        .explore_en   (explore_en),
        .rd_en        (rd_en),
        .rd_state     (rd_state),
        .rd_action    (rd_action),
        .rd_data      (rd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_action   (rsp_action),
        .rsp_max_q    (rsp_max_q),
        .rsp_explored (rsp_explored)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    // Synchronous Q-RAM: garbage whenever no read was issued.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_state][rd_action];
        else       rd_data <= 16'($urandom);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) tb_lfsr <= 16'hACE1;
        else     tb_lfsr <= ref_step(tb_lfsr);
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_action",   rsp_action,   e.action);
                check("sb_max_q",    rsp_max_q,    e.max_q);
                check("sb_explored", rsp_explored, e.explored);
            end
        end
    end

    task automatic run_req(input logic [3:0] s, input logic exp_en, input int hold);
        exp_t             e;
        logic signed [15:0] bq;
        logic [1:0]       ba;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        bq = mem[s][0];
        ba = 2'd0;
        for (int a = 1; a < 4; a++) begin
            if ($signed(mem[s][a]) > bq) begin
                bq = mem[s][a];
                ba = 2'(a);
            end
        end
        e.explored = exp_en && (tb_lfsr < EPS);
        e.action   = e.explored ? tb_lfsr[1:0] : ba;
        e.max_q    = bq;
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_state  = s;
        explore_en = exp_en;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_state  = ~s;
        explore_en = ~exp_en;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("scan_rd_en",     rd_en,     1);
            check("scan_rd_action", rd_action, k);
            check("scan_rd_state",  rd_state,  s);
            check("scan_req_ready", req_ready, 0);
            check("scan_rsp_valid", rsp_valid, 0);
        end
        @(negedge clk);
        check("drain_rd_en",     rd_en,     0);
        check("drain_rsp_valid", rsp_valid, 0);
        rsp_ready = (hold == 0);
        @(negedge clk);
        check("rsp_valid_t6", rsp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check("hold_rsp_valid", rsp_valid,    1);
            check("hold_action",    rsp_action,   e.action);
            check("hold_max_q",     rsp_max_q,    e.max_q);
            check("hold_explored",  rsp_explored, e.explored);
            check("hold_req_ready", req_ready,    0);
            check("hold_rd_en",     rd_en,        0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("hs_rsp_valid", rsp_valid, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    task automatic reset_mid_scan(input logic [3:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_state = s;
        explore_en = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_rd_en", rd_en, 1);
        rst = 1'b1;
        #1;
        check("rst_rd_en",     rd_en,     0);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_state  = '0;
        explore_en = 1'b0;
        rsp_ready  = 1'b0;
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 4; a++)
                mem[s][a] = 16'($urandom);
        mem[3] = '{16'd10, 16'hFFFB, 16'd42, 16'd7};
        mem[5] = '{16'd5, 16'd5, 16'd5, 16'd5};
        mem[1] = '{16'hFFF8, 16'hFFFD, 16'hFF9C, 16'hFFFD};
        mem[2] = '{16'h8000, 16'h8000, 16'h8001, 16'h8000};
        mem[6] = '{16'd100, 16'h8000, 16'd300, 16'd200};

        repeat (3) @(negedge clk);
        check("rst_req_ready0",    req_ready,    1);
        check("rst_rd_en0",        rd_en,        0);
        check("rst_rsp_valid0",    rsp_valid,    0);
        check("rst_rsp_action0",   rsp_action,   0);
        check("rst_rsp_max_q0",    rsp_max_q,    0);
        check("rst_rsp_explored0", rsp_explored, 0);
        check("rst_rd_state0",     rd_state,     0);
        check("rst_rd_action0",    rd_action,    0);
        rst = 1'b0;

        run_req(4'd3, 1'b0, 0);
        run_req(4'd5, 1'b0, 0);
        run_req(4'd1, 1'b0, 0);
        run_req(4'd2, 1'b0, 5);
        reset_mid_scan(4'd3);
        run_req(4'd3, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_req(4'd6, 1'b1, i);
        end
        run_req(4'd6, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            run_req(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
